// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C config sequencer.
// State encoding, entry layout, width helpers.
package i2c_seq_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_XFER  = 3'd3,
    S_NEXT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Host request and I2C master bundle.
// master: sequencer side, slave: host/master side.
interface i2c_config_sequencer_if;
  import i2c_seq_pkg::*;

  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ack;
  logic              i2c_start;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_data;
  logic              i2c_ready;

  modport master (
    input  host_req,
    input  host_addr,
    input  host_data,
    input  i2c_ready,
    output host_ack,
    output i2c_start,
    output i2c_addr,
    output i2c_data
  );

  modport slave (
    output host_req,
    output host_addr,
    output host_data,
    output i2c_ready,
    input  host_ack,
    input  i2c_start,
    input  i2c_addr,
    input  i2c_data
  );

endinterface

// File: rtl/i2c_config_rom.sv
// Init table: index -> {addr[6:0], data[7:0]}.
// Out-of-range indices read as zero.
module i2c_config_rom
  import i2c_seq_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic [IW-1:0] index,
  output entry_t        entry
);

  logic [31:0] idx;

  assign idx = 32'(index);

  // Table lookup
  always_comb begin
    entry = '0;
    case (idx)
      32'd0:   entry = {7'h1A, 8'h01};
      32'd1:   entry = {7'h1A, 8'h2F};
      32'd2:   entry = {7'h34, 8'h80};
      32'd3:   entry = {7'h34, 8'h15};
      32'd4:   entry = {7'h48, 8'hC3};
      32'd5:   entry = {7'h48, 8'h07};
      32'd6:   entry = {7'h6E, 8'h9A};
      32'd7:   entry = {7'h6E, 8'hF0};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the config ROM into an I2C master at init,
// and services single host writes in between.
module i2c_config_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NUM_WORDS      = 8,
  parameter int ACCEPT_TIMEOUT = 4095,
  parameter int XFER_TIMEOUT   = 1048575,
  parameter bit AUTO_INIT      = 1'b1
) (
  input  logic                   ref_clk,
  input  logic                   reset,
  input  logic                   init_start,
  i2c_config_sequencer_if.master bus,
  output logic                   busy,
  output logic                   init_done,
  output logic                   error,
  output logic [2:0]             o_state
);

  localparam int IW = idx_width(NUM_WORDS);
  localparam int CW = cnt_width(XFER_TIMEOUT);

  localparam logic [IW-1:0] LAST_IDX =
    IW'(NUM_WORDS - 1);
  localparam logic [31:0] ACC_LIM =
    32'(ACCEPT_TIMEOUT);
  localparam logic [31:0] XFR_LIM =
    32'(XFER_TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     index;
  logic [IW-1:0]     index_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [CW-1:0]     cnt_inc;
  logic              sync1;
  logic              sync2;
  logic              ready_s;
  logic              auto_pend;
  logic              auto_pend_nxt;
  logic              is_host;
  logic              is_host_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              acc_to;
  logic              xfer_to;
  logic              load_en;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  entry_t            rom_entry;

  assign ready_s   = sync2;
  assign cnt_inc   = (&cnt) ? cnt : cnt + CW'(1);
  assign acc_to    = 32'(cnt) >= ACC_LIM;
  assign xfer_to   = 32'(cnt) >= XFR_LIM;
  assign load_en   = (state_nxt == S_LOAD) &&
                     (state != S_LOAD);
  assign o_state   = state;
  assign init_done = done_q;
  assign bus.i2c_addr = addr_q;
  assign bus.i2c_data = data_q;

  // ROM is addressed by the next index so the
  // entry is captured on the edge entering LOAD
  i2c_config_rom #(
    .IW (IW)
  ) u_rom (
    .index (index_nxt),
    .entry (rom_entry)
  );

  // Two-flop synchronizer for the master ready flag
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.i2c_ready;
      sync2 <= sync1;
    end
  end

  // FSM and bookkeeping registers
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      index     <= '0;
      cnt       <= '0;
      auto_pend <= AUTO_INIT;
      is_host   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      cnt       <= cnt_nxt;
      auto_pend <= auto_pend_nxt;
      is_host   <= is_host_nxt;
      done_q    <= done_nxt;
    end
  end

  // Transfer target, held from LOAD through XFER
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load_en) begin
      if (is_host_nxt) begin
        addr_q <= bus.host_addr;
        data_q <= bus.host_data;
      end else begin
        addr_q <= rom_entry[ENTRY_W-1:DATA_W];
        data_q <= rom_entry[DATA_W-1:0];
      end
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt     = state;
    index_nxt     = index;
    cnt_nxt       = cnt;
    auto_pend_nxt = auto_pend;
    is_host_nxt   = is_host;
    done_nxt      = done_q;
    busy          = 1'b0;
    error         = 1'b0;
    bus.i2c_start = 1'b0;
    bus.host_ack  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (init_start || auto_pend) begin
          state_nxt     = S_LOAD;
          index_nxt     = '0;
          done_nxt      = 1'b0;
          is_host_nxt   = 1'b0;
          auto_pend_nxt = 1'b0;
        end else if (bus.host_req) begin
          state_nxt   = S_LOAD;
          is_host_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        cnt_nxt = '0;
        if (ready_s) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        busy          = 1'b1;
        bus.i2c_start = 1'b1;
        if (!ready_s) begin
          state_nxt = S_XFER;
          cnt_nxt   = '0;
        end else if (acc_to) begin
          state_nxt = S_ERROR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_XFER: begin
        busy = 1'b1;
        if (ready_s) begin
          state_nxt = S_NEXT;
        end else if (xfer_to) begin
          state_nxt = S_ERROR;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_NEXT: begin
        busy = 1'b1;
        if (is_host) begin
          bus.host_ack = 1'b1;
          state_nxt    = S_IDLE;
        end else if (index == LAST_IDX) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          index_nxt = index + IW'(1);
          state_nxt = S_LOAD;
        end
      end
      S_ERROR: begin
        error = 1'b1;
        if (init_start) begin
          state_nxt   = S_LOAD;
          index_nxt   = '0;
          done_nxt    = 1'b0;
          is_host_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized bench for i2c_config_sequencer.
// Expected start sequence is built from the table and host writes.
module tb_i2c_config_sequencer;
  import i2c_seq_pkg::*;

  localparam int NW    = 3;
  localparam int ACC_T = 15;
  localparam int XFR_T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_start = 1'b0;
  logic       busy;
  logic       init_done;
  logic       error;
  logic [2:0] o_state;
  logic       m_ready = 1'b1;
  logic       glitch = 1'b0;
  bit         master_en = 1'b1;
  int         busy_len = 20;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int load_cnt = 0;
  int viol = 0;

  logic [14:0] seen_q[$];
  logic [14:0] exp_q[$];

  logic [14:0] rom_ref [8] = '{
    {7'h1A, 8'h01}, {7'h1A, 8'h2F},
    {7'h34, 8'h80}, {7'h34, 8'h15},
    {7'h48, 8'hC3}, {7'h48, 8'h07},
    {7'h6E, 8'h9A}, {7'h6E, 8'hF0}
  };

  i2c_config_sequencer_if bus();

  assign bus.i2c_ready = m_ready & ~glitch;

  i2c_config_sequencer #(
    .NUM_WORDS      (NW),
    .ACCEPT_TIMEOUT (ACC_T),
    .XFER_TIMEOUT   (XFR_T),
    .AUTO_INIT      (1'b1)
  ) dut (
    .ref_clk    (clk),
    .reset      (rst),
    .init_start (init_start),
    .bus        (bus),
    .busy       (busy),
    .init_done  (init_done),
    .error      (error),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Model I2C master: latches each start, busy busy_len
  initial begin
    forever begin
      @(negedge clk);
      if (master_en && bus.i2c_start && m_ready) begin
        seen_q.push_back({bus.i2c_addr, bus.i2c_data});
        m_ready = 1'b0;
        repeat (busy_len) @(negedge clk);
        m_ready = 1'b1;
      end
    end
  end

  // Protocol monitor
  initial begin
    logic [2:0]  pst;
    logic [14:0] pad;
    logic        pack;
    pst = 3'd0;
    pad = '0;
    pack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.host_ack) ack_cnt++;
      if (o_state == 3'd1) load_cnt++;
      if (bus.host_ack && pack) viol++;
      if (bus.i2c_start && o_state != 3'd2) viol++;
      if (pst inside {3'd1, 3'd2, 3'd3} &&
          o_state inside {3'd1, 3'd2, 3'd3} &&
          {bus.i2c_addr, bus.i2c_data} != pad)
        viol++;
      pst  = o_state;
      pad  = {bus.i2c_addr, bus.i2c_data};
      pack = bus.host_ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic push_rom();
    for (int i = 0; i < NW; i++)
      exp_q.push_back(rom_ref[i]);
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() &&
                    i < seen_q.size(); i++)
      check($sformatf("%s_e%0d", tag, i),
            32'(seen_q[i]), 32'(exp_q[i]));
    seen_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_init();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(o_state == 3'd0 && init_done) &&
           n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(init_done && !busy), 1);
    compare_q(tag);
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input string tag);
    int n = 0;
    while (o_state != s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, o_state, s);
  endtask

  task automatic host_write(input logic [6:0] a,
                            input logic [7:0] d,
                            input string tag);
    int n = 0;
    int a0;
    exp_q.push_back({a, d});
    a0 = ack_cnt;
    bus.host_addr = a;
    bus.host_data = d;
    bus.host_req  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.host_ack && n < 5000);
    bus.host_req = 1'b0;
    check({tag, "_ack"}, 32'(bus.host_ack), 1);
    @(negedge clk);
    check({tag, "_ackn"}, ack_cnt - a0, 1);
    compare_q(tag);
  endtask

  initial begin
    int n;
    int a0;
    int l0;
    bus.host_req  = 1'b0;
    bus.host_addr = '0;
    bus.host_data = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_state", o_state, 0);
    check("rst_start", 32'(bus.i2c_start), 0);
    check("rst_addr", 32'(bus.i2c_addr), 0);
    check("rst_data", 32'(bus.i2c_data), 0);
    check("rst_ack", 32'(bus.host_ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(init_done), 0);
    check("rst_err", 32'(error), 0);

    // auto init walk
    rst = 1'b0;
    @(negedge clk);
    check("auto_busy", 32'(busy), 1);
    push_rom();
    wait_done("auto");
    check("auto_noack", ack_cnt, 0);

    // fixed host write
    repeat (3) @(negedge clk);
    host_write(7'h1A, 8'h5C, "host_fix");
    check("host_keep_done", 32'(init_done), 1);

    // init and host in the same cycle
    repeat (2) @(negedge clk);
    push_rom();
    fork
      pulse_init();
      host_write(7'h55, 8'hA7, "both");
    join
    check("both_done", 32'(init_done), 1);

    // init_start while busy is ignored
    push_rom();
    pulse_init();
    repeat (30) @(negedge clk);
    pulse_init();
    wait_done("reinit");

    // host request raised during a walk
    push_rom();
    pulse_init();
    repeat (40) @(negedge clk);
    host_write(7'h2B, 8'h3D, "host_mid");

    // randomized host writes and walks
    for (int k = 0; k < 6; k++) begin
      busy_len = $urandom_range(4, 30);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      host_write(7'($urandom), 8'($urandom),
                 $sformatf("rnd_h%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      busy_len = $urandom_range(4, 30);
      push_rom();
      pulse_init();
      wait_done($sformatf("rnd_w%0d", k));
    end

    // one-cycle ready glitch lands in LOAD
    busy_len = 10;
    repeat (3) @(negedge clk);
    l0 = load_cnt;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    host_write(7'h0F, 8'hE1, "glitch");
    check("glitch_load", load_cnt - l0, 2);

    // accept timeout
    master_en = 1'b0;
    pulse_init();
    wait_state(3'd2, "acc");
    n = 0;
    while (o_state != 3'd5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("acc_cycles", n, ACC_T + 1);
    check("acc_err", 32'(error), 1);
    check("acc_start", 32'(bus.i2c_start), 0);
    check("acc_busy", 32'(busy), 0);
    a0 = ack_cnt;
    bus.host_req = 1'b1;
    repeat (10) @(negedge clk);
    check("err_hold", o_state, 5);
    bus.host_req = 1'b0;
    @(negedge clk);
    check("err_noack", ack_cnt - a0, 0);
    master_en = 1'b1;
    push_rom();
    pulse_init();
    check("err_clr", 32'(error), 0);
    check("err_load", o_state, 1);
    wait_done("err_walk");

    // transfer timeout
    busy_len = 300;
    exp_q.push_back(rom_ref[0]);
    pulse_init();
    wait_state(3'd3, "xfr");
    busy_len = 10;
    n = 0;
    while (o_state != 3'd5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("xfr_cycles", n, XFR_T + 1);
    check("xfr_err", 32'(error), 1);
    compare_q("xfr");
    push_rom();
    pulse_init();
    wait_done("xfr_walk");

    // reset during transfer of entry 2
    busy_len = 20;
    pulse_init();
    n = 0;
    while (seen_q.size() < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_seen", seen_q.size(), 3);
    wait_state(3'd3, "mid");
    rst = 1'b1;
    @(negedge clk);
    check("mid_state", o_state, 0);
    check("mid_start", 32'(bus.i2c_start), 0);
    check("mid_addr", 32'(bus.i2c_addr), 0);
    check("mid_data", 32'(bus.i2c_data), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(init_done), 0);
    check("mid_err", 32'(error), 0);
    rst = 1'b0;
    seen_q.delete();
    exp_q.delete();
    push_rom();
    @(negedge clk);
    wait_done("mid_walk");

    check("monitor", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
